event_encoder_4_to_2: RTL and testbench

- Sequential 4-to-2 encoder: the inverse of the team's 2-to-4 decoder.
- Captures events on four request lines into a pending register and arbitrates among pending bits.
- Presents the winning index as a 2-bit code (d1:d0 weighting, bit0 = LSB) on a valid/ready handshake.
- Clears each serviced bit on acceptance; used as the event/interrupt encoder feeding downstream decode logic.

---
 rtl/event_encoder_4_to_2.sv | 200 ++++++++++++++++++++
 tb/tb_event_encoder_4_to_2.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/event_encoder_4_to_2.sv
// ============================================================================
// event_encoder_4_to_2
// ----------------------------------------------------------------------------
// Sequential 4-to-2 event encoder, the counterpart of the team's 2-to-4
// decoder. Events on four request lines are latched into a pending register.
// An arbiter picks one pending index and presents it as a 2-bit binary code
// on a valid/ready handshake. Each serviced bit is cleared when accepted.
//
// Parameters
//   EDGE_DET : 1 = capture on rising edge of req[i], 0 = capture on level
//   RR_MODE  : 0 = fixed priority (index 3 highest), 1 = round-robin
//
// Ports
//   clk   in   1  single clock, every register updates on its rising edge
//   rst   in   1  synchronous active-high reset
//   req   in   4  event request lines, req[i] belongs to index i
//   ready in   1  downstream accepts the code when high together with valid
//   valid out  1  code holds a granted index
//   code  out  2  binary index of the granted request (bit0 = LSB)
//   pend  out  4  current pending register, for observability
//   ovf   out  1  lost-event pulse, present only with EVENT_ENC_OVF_EN
//
// Optional feature macro: EVENT_ENC_OVF_EN
//   Adds the ovf output. ovf pulses for one cycle after any edge on which a
//   new event hits an index that is already pending and not being cleared.
//   Without the macro such a collision silently merges into the pending bit.
// ============================================================================
module event_encoder_4_to_2 #(
    parameter int EDGE_DET = 1,
    parameter int RR_MODE  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       ready,
    output logic       valid,
    output logic [1:0] code,
    output logic [3:0] pend
`ifdef EVENT_ENC_OVF_EN
    ,
    output logic       ovf
`endif
);

    // IDLE waits for something pending, HOLD presents a code until accepted.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] pend_q, pend_d;
    logic [3:0] reqPrev_q, reqPrev_d;
    logic       valid_q, valid_d;
    logic [1:0] code_q, code_d;
    logic [1:0] ptr_q, ptr_d;

    logic [3:0] setMask;
    logic [3:0] clrMask;
    logic       accept;
    logic [1:0] selIdx;

`ifdef EVENT_ENC_OVF_EN
    logic       ovf_q, ovf_d;
    logic       lostEvent;
`endif

    // Event capture: a new event is either a rising edge of req or simply a
    // high level, depending on EDGE_DET. The history register follows req
    // every cycle regardless of the mode.
    always_comb begin
        if (EDGE_DET != 0) begin
            setMask = req & ~reqPrev_q;
        end else begin
            setMask = req;
        end
        reqPrev_d = req;
    end

    // Handshake completion clears exactly the bit that was presented. The new
    // event is OR-ed in after the clear so a same-cycle re-trigger survives
    // as a fresh pending event.
    always_comb begin
        accept  = valid_q & ready;
        clrMask = accept ? (4'b0001 << code_q) : 4'b0000;
        pend_d  = (pend_q & ~clrMask) | setMask;
    end

`ifdef EVENT_ENC_OVF_EN
    // A collision is a new event on an index that stays pending anyway, so
    // the earlier occurrence is swallowed. Clearing the same bit in that
    // cycle makes room for the new event and is not a loss.
    always_comb begin
        lostEvent = |(setMask & pend_q & ~clrMask);
        ovf_d     = lostEvent;
    end
`endif

    // Arbiter, looking only at the registered pending bits.
    // Fixed priority: walk upward so the highest set index is written last.
    // Round-robin: walk the search order backwards (ptr+4 ... ptr+1) so the
    // first index after the pointer is written last and therefore wins.
    always_comb begin
        logic [1:0] cand;
        cand   = 2'd0;
        selIdx = 2'd0;
        if (RR_MODE != 0) begin
            for (int k = 4; k >= 1; k--) begin
                cand = ptr_q + 2'(k);
                if (pend_q[cand]) begin
                    selIdx = cand;
                end
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (pend_q[i]) begin
                    selIdx = 2'(i);
                end
            end
        end
    end

    // State register plus all datapath registers. Reset wins over any
    // handshake in flight; the round-robin pointer resets to 3 so index 0
    // is searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pend_q    <= 4'b0000;
            reqPrev_q <= 4'b0000;
            valid_q   <= 1'b0;
            code_q    <= 2'd0;
            ptr_q     <= 2'd3;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            reqPrev_q <= reqPrev_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
            ptr_q     <= ptr_d;
        end
    end

`ifdef EVENT_ENC_OVF_EN
    // Overflow flag register, one-cycle pulse per colliding edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
`endif

    // Next-state logic. A grant is loaded in IDLE and held untouched in
    // HOLD, so later events can never disturb a presented code. Returning to
    // IDLE after an accept gives the single bubble cycle between grants.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        code_d  = code_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    code_d  = selIdx;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else begin
                    valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (accept) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                    if (RR_MODE != 0) begin
                        ptr_d = code_q;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Outputs come straight from registers, so neither req nor ready has a
    // combinational path to them.
    always_comb begin
        valid = valid_q;
        code  = code_q;
        pend  = pend_q;
`ifdef EVENT_ENC_OVF_EN
        ovf   = ovf_q;
`endif
    end

endmodule

// File: tb/tb_event_encoder_4_to_2.sv
// ============================================================================
// tb_event_encoder_4_to_2
// ----------------------------------------------------------------------------
// Drives two encoders from the same stimulus: dutF uses fixed priority and
// dutR uses round-robin, both with rising-edge capture. A behavioural model
// for each instance is stepped on every rising edge and compared against the
// DUT on every falling edge; directed scenarios add literal expectations,
// including the order of accepted codes.
// Ports: none (self-contained bench).
// ============================================================================
`timescale 1ns / 1ps
module tb_event_encoder_4_to_2;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       ready;

    logic       validF, validR;
    logic [1:0] codeF, codeR;
    logic [3:0] pendF, pendR;
`ifdef EVENT_ENC_OVF_EN
    logic       ovfF, ovfR;
`endif

    int nCompared;
    int nMismatched;
    bit modelOn;

    // Accepted codes, logged just before the edge that accepts them.
    int grantsF[$];
    int grantsR[$];

    // Behavioural model state, index 0 = fixed priority, 1 = round-robin.
    logic [3:0] mPend[2];
    logic [3:0] mPrev[2];
    bit         mValid[2];
    int         mCode[2];
    int         mLast[2];
    bit         mOvf[2];

    event_encoder_4_to_2 #(.EDGE_DET(1), .RR_MODE(0)) dutF (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .ready (ready),
        .valid (validF),
        .code  (codeF),
        .pend  (pendF)
`ifdef EVENT_ENC_OVF_EN
        ,
        .ovf   (ovfF)
`endif
    );

    event_encoder_4_to_2 #(.EDGE_DET(1), .RR_MODE(1)) dutR (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .ready (ready),
        .valid (validR),
        .code  (codeR),
        .pend  (pendR)
`ifdef EVENT_ENC_OVF_EN
        ,
        .ovf   (ovfR)
`endif
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the bench can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    // One model step from the rules: serve the accepted index, merge new
    // events (new event beats the clear), and grant from the old pending set
    // when nothing is presented.
    task automatic stepModel(input int m);
        bit         acc;
        int         served;
        int         pick;
        logic [3:0] oldPend;
        logic [3:0] newEv;
        bit         lost;
        if (rst) begin
            mPend[m]  = 4'b0000;
            mPrev[m]  = 4'b0000;
            mValid[m] = 1'b0;
            mCode[m]  = 0;
            mLast[m]  = 3;
            mOvf[m]   = 1'b0;
        end else begin
            acc     = mValid[m] && (ready === 1'b1);
            served  = acc ? mCode[m] : -1;
            oldPend = mPend[m];
            lost    = 1'b0;
            for (int i = 0; i < 4; i++) begin
                newEv[i] = req[i] && !mPrev[m][i];
                if (newEv[i] && oldPend[i] && (i != served)) lost = 1'b1;
            end
            for (int i = 0; i < 4; i++) begin
                if (i == served) mPend[m][i] = 1'b0;
                if (newEv[i]) mPend[m][i] = 1'b1;
            end
            if (acc) begin
                mValid[m] = 1'b0;
                mLast[m]  = served;
            end else if (!mValid[m] && (oldPend != 4'b0000)) begin
                pick = -1;
                if (m == 0) begin
                    for (int i = 3; i >= 0; i--) begin
                        if (pick < 0 && oldPend[i]) pick = i;
                    end
                end else begin
                    for (int k = 1; k <= 4; k++) begin
                        if (pick < 0 && oldPend[(mLast[m] + k) % 4]) pick = (mLast[m] + k) % 4;
                    end
                end
                mValid[m] = 1'b1;
                mCode[m]  = pick;
            end
            mPrev[m] = req;
            mOvf[m]  = lost;
        end
    endtask

    always @(posedge clk) begin
        stepModel(0);
        stepModel(1);
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (modelOn) begin
            checkOutput("model F.valid", validF, mValid[0]);
            checkOutput("model F.pend", pendF, mPend[0]);
            if (mValid[0]) checkOutput("model F.code", codeF, mCode[0]);
            checkOutput("model R.valid", validR, mValid[1]);
            checkOutput("model R.pend", pendR, mPend[1]);
            if (mValid[1]) checkOutput("model R.code", codeR, mCode[1]);
`ifdef EVENT_ENC_OVF_EN
            checkOutput("model F.ovf", ovfF, mOvf[0]);
            checkOutput("model R.ovf", ovfR, mOvf[1]);
`endif
        end
    end

    // Advance n falling edges; before each wait, log codes that the coming
    // rising edge will accept.
    task automatic tick(input int n);
        repeat (n) begin
            if (!rst && ready) begin
                if (validF) grantsF.push_back(int'(codeF));
                if (validR) grantsR.push_back(int'(codeR));
            end
            @(negedge clk);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic rd, input int n);
        req   = r;
        ready = rd;
        tick(n);
    endtask

    task automatic checkGrants(input string name, input int which, input int n,
                               input int e0, input int e1, input int e2, input int e3);
        int exp[4];
        int gotN;
        int got;
        exp  = '{e0, e1, e2, e3};
        gotN = (which == 0) ? grantsF.size() : grantsR.size();
        checkOutput({name, ".count"}, gotN, n);
        for (int k = 0; k < n; k++) begin
            got = -1;
            if (k < gotN) got = (which == 0) ? grantsF[k] : grantsR[k];
            checkOutput($sformatf("%s[%0d]", name, k), got, exp[k]);
        end
    endtask

    task automatic clearGrants();
        grantsF.delete();
        grantsR.delete();
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        modelOn     = 1'b0;
        rst         = 1'b1;
        req         = 4'b0000;
        ready       = 1'b0;
        @(negedge clk);
        tick(2);

        // Reset state.
        checkOutput("reset F.valid", validF, 1'b0);
        checkOutput("reset F.code", codeF, 2'd0);
        checkOutput("reset F.pend", pendF, 4'b0000);
        checkOutput("reset R.valid", validR, 1'b0);
        checkOutput("reset R.pend", pendR, 4'b0000);
        rst     = 1'b0;
        modelOn = 1'b1;
        tick(1);

        // One-cycle pulse on 1011 with ready high.
        applyStimulus(4'b1011, 1'b1, 1);
        checkOutput("fp capture pend", pendF, 4'b1011);
        checkOutput("fp capture valid", validF, 1'b0);
        applyStimulus(4'b0000, 1'b1, 1);
        checkOutput("fp first valid", validF, 1'b1);
        checkOutput("fp first code", codeF, 2'd3);
        checkOutput("rr first code", codeR, 2'd0);
        tick(1);
        checkOutput("fp bubble valid", validF, 1'b0);
        tick(5);
        checkGrants("fp order F", 0, 3, 3, 1, 0, 0);
        checkGrants("fp order R", 1, 3, 0, 1, 3, 0);
        checkOutput("fp end pend", pendF, 4'b0000);
        clearGrants();

        // Pulse on all four lines, then on 1001.
        applyStimulus(4'b1111, 1'b1, 1);
        applyStimulus(4'b0000, 1'b1, 9);
        checkGrants("rr all R", 1, 4, 0, 1, 2, 3);
        checkGrants("rr all F", 0, 4, 3, 2, 1, 0);
        clearGrants();
        applyStimulus(4'b1001, 1'b1, 1);
        applyStimulus(4'b0000, 1'b1, 5);
        checkGrants("rr 1001 R", 1, 2, 0, 3, 0, 0);
        checkGrants("rr 1001 F", 0, 2, 3, 0, 0, 0);
        clearGrants();

        // Backpressure: code 1 held while req[3] pulses.
        applyStimulus(4'b0010, 1'b0, 1);
        applyStimulus(4'b0000, 1'b0, 1);
        checkOutput("bp valid", validF, 1'b1);
        checkOutput("bp code", codeF, 2'd1);
        applyStimulus(4'b1000, 1'b0, 1);
        applyStimulus(4'b0000, 1'b0, 4);
        checkOutput("bp held F.code", codeF, 2'd1);
        checkOutput("bp held R.code", codeR, 2'd1);
        checkOutput("bp held F.pend", pendF, 4'b1010);
        checkOutput("bp held R.pend", pendR, 4'b1010);
        checkOutput("bp held valid", validF, 1'b1);
        applyStimulus(4'b0000, 1'b1, 4);
        checkGrants("bp order F", 0, 2, 1, 3, 0, 0);
        checkGrants("bp order R", 1, 2, 1, 3, 0, 0);
        clearGrants();

        // Accept code 2 on the same edge req[2] rises again.
        applyStimulus(4'b0100, 1'b0, 1);
        applyStimulus(4'b0000, 1'b0, 1);
        checkOutput("coll pre code", codeF, 2'd2);
        applyStimulus(4'b0100, 1'b1, 1);
        checkOutput("coll F.pend", pendF, 4'b0100);
        checkOutput("coll R.pend", pendR, 4'b0100);
        checkOutput("coll valid", validF, 1'b0);
`ifdef EVENT_ENC_OVF_EN
        checkOutput("coll ovf", ovfF, 1'b0);
`endif
        applyStimulus(4'b0000, 1'b1, 1);
        checkOutput("coll regrant valid", validF, 1'b1);
        checkOutput("coll regrant code", codeF, 2'd2);
        tick(2);
        checkGrants("coll order F", 0, 2, 2, 2, 0, 0);
        checkOutput("coll end pend", pendF, 4'b0000);
        clearGrants();

        // Two separate req[0] pulses while ready is low.
        applyStimulus(4'b0001, 1'b0, 1);
        applyStimulus(4'b0000, 1'b0, 1);
        applyStimulus(4'b0001, 1'b0, 1);
`ifdef EVENT_ENC_OVF_EN
        checkOutput("ovf pulse", ovfF, 1'b1);
`endif
        checkOutput("ovf merged pend", pendF, 4'b0001);
        applyStimulus(4'b0000, 1'b0, 1);
`ifdef EVENT_ENC_OVF_EN
        checkOutput("ovf pulse end", ovfF, 1'b0);
`endif
        applyStimulus(4'b0000, 1'b1, 3);
        checkGrants("ovf drain F", 0, 1, 0, 0, 0, 0);
        checkOutput("ovf drain pend", pendF, 4'b0000);
        clearGrants();

        // Reset while a grant is held; req released as reset drops.
        applyStimulus(4'b0100, 1'b0, 1);
        applyStimulus(4'b0100, 1'b0, 1);
        checkOutput("rst hold valid", validF, 1'b1);
        checkOutput("rst hold code", codeF, 2'd2);
        rst = 1'b1;
        applyStimulus(4'b0100, 1'b0, 1);
        checkOutput("rst mid F.valid", validF, 1'b0);
        checkOutput("rst mid F.code", codeF, 2'd0);
        checkOutput("rst mid F.pend", pendF, 4'b0000);
        checkOutput("rst mid R.valid", validR, 1'b0);
        rst = 1'b0;
        applyStimulus(4'b0000, 1'b1, 4);
        checkOutput("rst after valid", validF, 1'b0);
        checkOutput("rst after pend", pendF, 4'b0000);
        checkGrants("rst after F", 0, 0, 0, 0, 0, 0);

        modelOn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
